// File: rtl/mine_neighbour_counter_pkg.sv
// Shared board geometry, FSM states and index helpers for mine_neighbour_counter.
package mine_pkg;
   localparam int ROWS  = 5;
   localparam int COLS  = 5;
   localparam int CELLS = ROWS * COLS;
   localparam int CW    = 4;
   localparam int IDXW  = $clog2(CELLS);
   localparam int RCW   = 3;
   localparam int TW    = 5;

   localparam logic [CW-1:0] CNT_MINE = 4'hF;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   typedef struct packed {
      logic [RCW-1:0] row;
      logic [RCW-1:0] col;
   } rc_t;

   function automatic rc_t idx_to_rc(input logic [IDXW-1:0] idx);
      rc_t rc;
      rc.row = RCW'(int'(idx) / COLS);
      rc.col = RCW'(int'(idx) % COLS);
      return rc;
   endfunction
endpackage

// File: rtl/cell_neighbour_count.sv
// Combinational edge-masked count of mines in the 8-neighbourhood of one cell.
module cell_neighbour_count
   import mine_pkg::*;
(
   input  logic [CELLS-1:0] snap_i,
   input  logic [RCW-1:0]   row_i,
   input  logic [RCW-1:0]   col_i,
   output logic [CW-1:0]    cnt_o
);
   int              rr;
   int              cc;
   logic [IDXW-1:0] nidx;

   always_comb begin
      cnt_o = '0;
      rr    = 0;
      cc    = 0;
      nidx  = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            rr = int'(row_i) + dr;
            cc = int'(col_i) + dc;
            // Off-board neighbours are skipped, so row ends never wrap.
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
               nidx  = IDXW'(rr * COLS + cc);
               cnt_o = cnt_o + CW'(snap_i[nidx]);
            end
         end
      end
   end
endmodule

// File: rtl/mine_neighbour_counter.sv
// Walks a 5x5 mine map one cell per clock, producing per-cell neighbour counts and a mine total.
// Optional MINE_MARK_EN: mined cells report CNT_MINE instead of their neighbour count.
module mine_neighbour_counter
   import mine_pkg::*;
(
   input  logic                in_clka,
   input  logic                in_rst_n,
   input  logic                in_start,
   input  logic [CELLS-1:0]    in_mines,
   output logic                out_busy,
   output logic                out_done,
   output logic [CELLS*CW-1:0] out_counts,
   output logic [TW-1:0]       out_mine_total
);
   state_t                     state_q, state_d;
   logic [CELLS-1:0]           snap_q;
   logic [IDXW-1:0]            idx_q;
   logic [TW-1:0]              total_q;
   logic [CELLS-1:0][CW-1:0]   counts_q;
   logic                       busy_q;
   logic                       done_q;
   rc_t                        rc;
   logic [CW-1:0]              nb_cnt;
   logic [CW-1:0]              cell_val;

   assign rc = idx_to_rc(idx_q);

   cell_neighbour_count u_cnt (
      .snap_i (snap_q),
      .row_i  (rc.row),
      .col_i  (rc.col),
      .cnt_o  (nb_cnt)
   );

`ifdef MINE_MARK_EN
   assign cell_val = snap_q[idx_q] ? CNT_MINE : nb_cnt;
`else
   assign cell_val = nb_cnt;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_start) state_d = SCAN;
         SCAN:    if (idx_q == IDXW'(CELLS - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge in_clka or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q  <= IDLE;
         snap_q   <= '0;
         idx_q    <= '0;
         total_q  <= '0;
         counts_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == SCAN);
         // The pulse lands on the cycle leaving DONE, i.e. the first IDLE cycle.
         done_q  <= (state_q == DONE);
         case (state_q)
            IDLE: if (in_start) begin
               snap_q   <= in_mines;
               idx_q    <= '0;
               total_q  <= '0;
               counts_q <= '0;
            end
            SCAN: begin
               counts_q[idx_q] <= cell_val;
               total_q         <= total_q + TW'(snap_q[idx_q]);
               idx_q           <= idx_q + IDXW'(1);
            end
            default: ;
         endcase
      end
   end

   assign out_busy       = busy_q;
   assign out_done       = done_q;
   assign out_counts     = counts_q;
   assign out_mine_total = total_q;
endmodule

// File: doc/mine_neighbour_counter.md
Name: mine_neighbour_counter

Overview:
- Sits directly downstream of the mine-placement RNG.
- Takes the 25-bit mine map, one bit per cell of the 5x5 board, and walks the board one cell per clock.
- For every cell it counts how many of its (up to 8) neighbours hold a mine, and also produces a running total of mines on the board.
- Results are held stable for the board/display logic until the next start.

Parameters:
- ROWS, 5, board rows.
- COLS, 5, board columns; CELLS = ROWS*COLS.
- CW, 4, width of each per-cell count field.

Ports:
- in_clka  input  1  system clock; all state updates on the rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_start  input  1  start request; honoured only in IDLE.
- in_mines  input  CELLS  mine map. Cell index = row*COLS + col; bit=1 means mine.
- out_busy  output  1  high while the scan is in progress.
- out_done  output  1  one-cycle pulse when the scan completes.
- out_counts  output  CELLS*CW  per-cell neighbour counts. Cell i occupies bits [i*CW +: CW].
- out_mine_total  output  5  total number of mines in the snapshot map (0..25).

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_busy=0, out_done=0, out_counts=0, out_mine_total=0; scan index and snapshot cleared.
- FSM states: IDLE -> SCAN -> DONE -> IDLE.
- IDLE:
  - On in_start=1, latch in_mines into a snapshot, zero the index and the running total, clear out_counts, set out_busy=1, go to SCAN.
- SCAN:
  - Each cycle writes the count for cell idx and adds snapshot[idx] to the total.
  - Increments idx; after idx=CELLS-1, go to DONE.
  - SCAN lasts exactly CELLS cycles (25).
- DONE:
  - out_done=1 for one cycle, out_busy=0, then IDLE.
  - With in_start sampled high at edge k, out_done is high in the cycle after edge k+26.
- Neighbour rule: sum of snapshot bits at (r±1, c±1), excluding (r, c).
  - Out-of-board neighbours count 0. No wrap: col 4 and col 0 of the next row are not adjacent.
  - The cell's own mine bit does not contribute.
  - Result range 0..8, zero-extended to CW.
- in_mines changes after the start edge do not affect the result; the snapshot is used throughout.
- in_start while out_busy=1 or in DONE is ignored; no queuing.
- in_start held high across DONE->IDLE starts a new scan on the next IDLE cycle.
- out_counts and out_mine_total:
  - Hold their final values from DONE until the next accepted start.
  - Partially written values are visible during SCAN; consumers sample on out_done.
- Reset mid-scan: immediate return to IDLE with all outputs at their reset values; no out_done pulse.

Optional Feature:
- Macro MINE_MARK_EN.
  - Defined: a cell whose own snapshot bit is 1 gets count 4'hF instead of its neighbour count. This is the mine marker for the display.
  - Undefined: every cell gets its neighbour count, whether or not it holds a mine.
- Total and timing are identical in both cases.

Decomposition:
- Shared package mine_pkg holds:
  - ROWS, COLS, CELLS, CW.
  - The FSM state enum (IDLE, SCAN, DONE).
  - Constant CNT_MINE = 4'hF.
  - Function idx_to_rc.
- One sub-module, cell_neighbour_count: combinational. Takes the snapshot, row and col; outputs the 4-bit edge-masked neighbour sum.
- The top level holds the FSM, index counter, snapshot, total accumulator and count register file.

Test Plan:
- in_mines=25'h0000001, start -> counts[1]=counts[5]=counts[6]=1, all others 0 (cell0=0, or F with MINE_MARK_EN); total=1; done exactly 26 cycles after the start edge.
- in_mines=bit12 only (centre) -> counts[6,7,8,11,13,16,17,18]=1, others 0; total=1.
- in_mines=25'h1FFFFFF -> corners (0,4,20,24)=3, other edge cells=5, interior=8 (all F with MINE_MARK_EN); total=25.
- in_mines=bit4 only -> counts[3]=counts[8]=counts[9]=1, counts[5]=0 (no row wrap).
- Pulse in_start again at scan cycle 10 and change in_mines mid-scan -> ignored; results match the original snapshot; a single done pulse.
- Assert in_rst_n=0 at scan cycle 12 -> out_busy=0, counts=0, total=0 immediately; no done; a fresh start after release completes normally.
